// File: rtl/add_serial_sched.sv
// add_serial_sched: round-robin arbiter sharing one bit-serial adder among NREQ requesters
module add_serial_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]         rsp_sum,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic                 add_en,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_out
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr, op_id, winner, idx;
    logic [W-1:0]   op_a, op_b;
    logic [CW-1:0]  wait_cnt;
    logic           found, grant;

    // Round-robin search upward from ptr with wrap-around; first valid requester wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k >= NREQ) ? IDW'(int'(ptr) + k - NREQ) : IDW'(int'(ptr) + k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant     = found && !rst && state == IDLE;
    assign req_ready = grant ? NREQ'(1) << winner : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign add_a     = op_a;
    assign add_b     = op_b;

    // Next state and adder strobe: add_en pulses once to start and once to release the adder
    always_comb begin
        state_nx = state;
        add_en   = 1'b0;
        case (state)
            IDLE:    state_nx = grant ? START : IDLE;
            START: begin
                add_en   = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    state_nx = (wait_cnt == CW'(LAT - 1)) ? CAPTURE : WAIT;
            CAPTURE: begin
                add_en   = 1'b1;
                state_nx = RESP;
            end
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // State, latched operands, wait counter, response registers and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            op_id    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            wait_cnt <= '0;
            rsp_sum  <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                op_a  <= req_a[winner*W +: W];
                op_b  <= req_b[winner*W +: W];
                op_id <= winner;
            end
            wait_cnt <= (state == START) ? '0 : (state == WAIT) ? wait_cnt + 1'b1 : wait_cnt;
            if (state == CAPTURE) begin
                rsp_sum <= add_out;
                rsp_id  <= op_id;
            end
            if (state == RESP && rsp_ready)
                ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
        end
    end
endmodule
